// File: rtl/bp_me_pkg.sv
// Shared ME types: CCE memory message layout, command/size encodings and the
// state type of the latency-model memory endpoint.
package bp_me_pkg;

  localparam int paddr_width_gp       = 40;
  localparam int cce_block_width_gp   = 512;
  localparam int cce_block_bytes_gp   = cce_block_width_gp / 8;
  localparam int cce_mem_payload_w_gp = 16;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3
  } bp_cce_mem_cmd_type_e;

  // Transfer size is 2^size bytes; anything wider than a block is clamped.
  typedef enum logic [2:0] {
    e_mem_size_1  = 3'd0,
    e_mem_size_2  = 3'd1,
    e_mem_size_4  = 3'd2,
    e_mem_size_8  = 3'd3,
    e_mem_size_16 = 3'd4,
    e_mem_size_32 = 3'd5,
    e_mem_size_64 = 3'd6
  } bp_mem_msg_size_e;

  typedef struct packed {
    bp_cce_mem_cmd_type_e            msg_type;
    logic [paddr_width_gp-1:0]       addr;
    bp_mem_msg_size_e                size;
    logic [cce_mem_payload_w_gp-1:0] payload;
    logic [cce_block_width_gp-1:0]   data;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_gp = $bits(bp_cce_mem_msg_s);

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_delay = 2'd1,
    e_resp  = 2'd2
  } bp_mem_model_state_e;

endpackage

// File: rtl/bp_mem_block_array.sv
// Block storage for the memory model: combinational read, byte-masked
// synchronous write, contents never reset.
module bp_mem_block_array
  import bp_me_pkg::*;
#(
  parameter int els_p   = 1024,
  parameter int width_p = cce_block_width_gp,
  localparam int idx_w_lp = $clog2(els_p),
  localparam int bytes_lp = width_p / 8
) (
  input  logic                clk_i,
  input  logic [idx_w_lp-1:0] addr_i,
  input  logic                w_v_i,
  input  logic [bytes_lp-1:0] w_mask_i,
  input  logic [width_p-1:0]  w_data_i,
  output logic [width_p-1:0]  r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  assign r_data_o = mem_q[addr_i];

  // NOTE: the array has no reset on purpose; clearing a RAM would need a
  // per-entry sweep, and retained contents across reset are part of the model.
  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      for (int b = 0; b < bytes_lp; b++) begin
        if (w_mask_i[b]) mem_q[addr_i][b*8 +: 8] <= w_data_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/bp_mem_latency_model.sv
// Single-outstanding DRAM stand-in: services a CCE mem command from a block
// array at the accept edge and presents the response mem_latency_p cycles later.
module bp_mem_latency_model
  import bp_me_pkg::*;
#(
  parameter int mem_latency_p = 4,
  parameter int mem_els_p     = 1024
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  bp_cce_mem_msg_s mem_cmd_i,
  input  logic            mem_cmd_v_i,
  output logic            mem_cmd_ready_o,
  output bp_cce_mem_msg_s mem_resp_o,
  output logic            mem_resp_v_o,
  input  logic            mem_resp_yumi_i
);

  localparam int off_lp   = $clog2(cce_block_bytes_gp);
  localparam int idx_w_lp = $clog2(mem_els_p);
  localparam int cnt_w_lp = $clog2(mem_latency_p + 1);

  bp_mem_model_state_e         state_q;
  logic [cnt_w_lp-1:0]         cnt_q;
  bp_cce_mem_msg_s             resp_q;
  bp_cce_mem_msg_s             resp_d;

  logic                        accept;
  logic                        known_type;
  logic [idx_w_lp-1:0]         blk_idx;
  logic [off_lp-1:0]           byte_off;
  logic [7:0]                  uc_bytes;
  logic [cce_block_bytes_gp-1:0] uc_mask;
  logic [cce_block_width_gp-1:0] rd_data;
  logic [cce_block_width_gp-1:0] rd_shifted;
  logic [cce_block_width_gp-1:0] uc_rd_data;
  logic [cce_block_width_gp-1:0] w_data;
  logic [cce_block_bytes_gp-1:0] w_mask;
  logic                        w_v;

  // Ready drops the instant reset asserts and returns as soon as it releases,
  // so the first posedge after release can already accept.
  assign mem_cmd_ready_o = reset_i & (state_q == e_ready);
  assign mem_resp_v_o    = (state_q == e_resp);
  assign mem_resp_o      = resp_q;
  assign accept          = mem_cmd_v_i & mem_cmd_ready_o;

  // Address bits above the index are ignored, so the array aliases.
  assign blk_idx  = mem_cmd_i.addr[off_lp +: idx_w_lp];
  assign byte_off = mem_cmd_i.addr[off_lp-1:0];
  assign uc_bytes = (mem_cmd_i.size >= 3'd6) ? 8'(cce_block_bytes_gp)
                                             : 8'(1 << mem_cmd_i.size);
  assign rd_shifted = rd_data >> {byte_off, 3'b000};

  always_comb begin
    uc_mask    = '0;
    uc_rd_data = '0;
    for (int b = 0; b < cce_block_bytes_gp; b++) begin
      uc_mask[b] = (b >= int'(byte_off)) && (b < int'(byte_off) + int'(uc_bytes));
      if (b < int'(uc_bytes)) uc_rd_data[b*8 +: 8] = rd_shifted[b*8 +: 8];
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_v         = 1'b0;
    w_mask      = '0;
    w_data      = mem_cmd_i.data;
    known_type  = 1'b1;
    resp_d      = mem_cmd_i;
    resp_d.data = '0;
    case (mem_cmd_i.msg_type)
      e_cce_mem_wr: begin
        w_v    = accept;
        w_mask = '1;
      end
      e_cce_mem_rd:    resp_d.data = rd_data;
      e_cce_mem_uc_wr: begin
        w_v    = accept;
        w_mask = uc_mask;
        w_data = mem_cmd_i.data << {byte_off, 3'b000};
      end
      e_cce_mem_uc_rd: resp_d.data = uc_rd_data;
      default:         known_type  = 1'b0;
    endcase
  end

  bp_mem_block_array #(
    .els_p   (mem_els_p),
    .width_p (cce_block_width_gp)
  ) blocks (
    .clk_i    (clk_i),
    .addr_i   (blk_idx),
    .w_v_i    (w_v),
    .w_mask_i (w_mask),
    .w_data_i (w_data),
    .r_data_o (rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= e_ready;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      case (state_q)
        e_ready: begin
          if (accept) begin
            resp_q  <= resp_d;
            cnt_q   <= cnt_w_lp'(mem_latency_p);
            state_q <= (mem_latency_p == 1) ? e_resp : e_delay;
          end
        end
        e_delay: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == cnt_w_lp'(1)) state_q <= e_resp;
        end
        e_resp: begin
          if (mem_resp_yumi_i) state_q <= e_ready;
        end
        default: state_q <= e_ready;
      endcase
    end
  end

  a_yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (!reset_i) mem_resp_yumi_i |-> mem_resp_v_o
  ) else $error("bp_mem_latency_model: mem_resp_yumi_i without mem_resp_v_o");

  a_known_msg_type: assert property (
    @(posedge clk_i) disable iff (!reset_i) accept |-> known_type
  ) else $error("bp_mem_latency_model: unknown msg_type accepted");

endmodule

// File: tb/tb_bp_mem_latency_model.sv
// Directed bench for bp_mem_latency_model: full/uncached reads and writes,
// latency, back-pressure and asynchronous reset behaviour.
module tb_bp_mem_latency_model;
  import bp_me_pkg::*;

  localparam int lat_lp = 4;
  localparam int msg_w  = $bits(bp_cce_mem_msg_s);

  logic            clk_i = 1'b0;
  logic            reset_i;
  bp_cce_mem_msg_s mem_cmd_i;
  logic            mem_cmd_v_i;
  logic            mem_cmd_ready_o;
  bp_cce_mem_msg_s mem_resp_o;
  logic            mem_resp_v_o;
  logic            mem_resp_yumi_i;

  int checks   = 0;
  int failures = 0;

  bp_mem_latency_model #(
    .mem_latency_p (lat_lp),
    .mem_els_p     (1024)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .mem_cmd_i       (mem_cmd_i),
    .mem_cmd_v_i     (mem_cmd_v_i),
    .mem_cmd_ready_o (mem_cmd_ready_o),
    .mem_resp_o      (mem_resp_o),
    .mem_resp_v_o    (mem_resp_v_o),
    .mem_resp_yumi_i (mem_resp_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [msg_w-1:0] got,
                       input logic [msg_w-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bp_cce_mem_msg_s mk(input bp_cce_mem_cmd_type_e t,
                                         input logic [39:0] a,
                                         input bp_mem_msg_size_e s,
                                         input logic [15:0] p,
                                         input logic [511:0] d);
    bp_cce_mem_msg_s m;
    m.msg_type = t;
    m.addr     = a;
    m.size     = s;
    m.payload  = p;
    m.data     = d;
    return m;
  endfunction

  // Present a command at a negedge, let it be accepted on the next posedge,
  // then count posedges until resp_v is seen (-1 if it never comes).
  task automatic issue(input string tag, input bp_cce_mem_msg_s cmd, output int lat);
    @(negedge clk_i);
    mem_cmd_i   = cmd;
    mem_cmd_v_i = 1'b1;
    check({tag, "_ready"}, msg_w'(mem_cmd_ready_o), msg_w'(1));
    @(posedge clk_i);
    #1 mem_cmd_v_i = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_i);
      #1;
      if (mem_resp_v_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic txn(input string tag, input bp_cce_mem_msg_s cmd,
                     input logic [511:0] exp_data);
    int lat;
    bp_cce_mem_msg_s exp;
    exp      = cmd;
    exp.data = exp_data;
    issue(tag, cmd, lat);
    check({tag, "_lat"}, msg_w'(lat), msg_w'(lat_lp));
    check({tag, "_resp"}, mem_resp_o, exp);
    mem_resp_yumi_i = 1'b1;
    @(posedge clk_i);
    #1 mem_resp_yumi_i = 1'b0;
    check({tag, "_done"}, msg_w'({mem_resp_v_o, mem_cmd_ready_o}), msg_w'(2'b01));
  endtask

  logic [511:0]    blk0, blk1, blk2, other;
  bp_cce_mem_msg_s stall_exp;
  int              lat;
  int              v_seen;

  initial begin
    reset_i         = 1'b0;
    mem_cmd_i       = '0;
    mem_cmd_v_i     = 1'b0;
    mem_resp_yumi_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      blk0[i*32 +: 32]  = 32'hA5A5_0000 + i;
      blk2[i*32 +: 32]  = 32'h5A5A_0000 + i;
      other[i*32 +: 32] = 32'h0BAD_0000 + i;
    end
    blk1           = blk0;
    blk1[64 +: 64] = 64'hDEAD_BEEF_CAFE_F00D;

    #1;
    check("reset_outs", msg_w'({mem_cmd_ready_o, mem_resp_v_o}), '0);
    check("reset_resp", mem_resp_o, '0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;
    #1 check("release_ready", msg_w'(mem_cmd_ready_o), msg_w'(1));

    txn("wr_blk", mk(e_cce_mem_wr, 40'h00_8000_0040, e_mem_size_64, 16'h1234, blk0), '0);
    txn("rd_blk", mk(e_cce_mem_rd, 40'h00_8000_0040, e_mem_size_64, 16'h4321, '0), blk0);
    txn("uc_wr8", mk(e_cce_mem_uc_wr, 40'h00_8000_0048, e_mem_size_8, 16'h00AA,
                     512'(64'hDEAD_BEEF_CAFE_F00D)), '0);
    txn("rd_after_uc", mk(e_cce_mem_rd, 40'h00_8000_0040, e_mem_size_64, 16'h0001, '0), blk1);
    txn("uc_rd4", mk(e_cce_mem_uc_rd, 40'h00_8000_004C, e_mem_size_4, 16'h0002, '0),
        512'(32'hDEAD_BEEF));
    txn("uc_rd_clamp", mk(e_cce_mem_uc_rd, 40'h00_8000_0040, bp_mem_msg_size_e'(3'd7),
                          16'h0003, '0), blk1);
    txn("rd_alias", mk(e_cce_mem_rd, 40'h00_8001_0040, e_mem_size_64, 16'h0004, '0), blk1);

    // Back-pressure: response held while a second command waits.
    stall_exp = mk(e_cce_mem_rd, 40'h00_8000_0040, e_mem_size_64, 16'h0005, blk1);
    issue("stall", mk(e_cce_mem_rd, 40'h00_8000_0040, e_mem_size_64, 16'h0005, '0), lat);
    check("stall_lat", msg_w'(lat), msg_w'(lat_lp));
    mem_cmd_i   = mk(e_cce_mem_wr, 40'h00_8000_00C0, e_mem_size_64, 16'h0006, other);
    mem_cmd_v_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i);
      #1;
      check("stall_resp", mem_resp_o, stall_exp);
      check("stall_flags", msg_w'({mem_resp_v_o, mem_cmd_ready_o}), msg_w'(2'b10));
    end
    mem_cmd_v_i     = 1'b0;
    mem_resp_yumi_i = 1'b1;
    @(posedge clk_i);
    #1 mem_resp_yumi_i = 1'b0;
    v_seen = 0;
    repeat (6) begin
      @(posedge clk_i);
      #1 if (mem_resp_v_o) v_seen++;
    end
    check("stall_no_2nd", msg_w'(v_seen), '0);

    // Asynchronous reset while a response is being presented.
    issue("rst_resp", mk(e_cce_mem_rd, 40'h00_8000_0040, e_mem_size_64, 16'h0007, '0), lat);
    check("rst_resp_lat", msg_w'(lat), msg_w'(lat_lp));
    reset_i = 1'b0;
    #1;
    check("rst_resp_outs", msg_w'({mem_cmd_ready_o, mem_resp_v_o}), '0);
    check("rst_resp_data", mem_resp_o, '0);
    @(negedge clk_i);
    reset_i = 1'b1;
    #1 check("rst_resp_release", msg_w'(mem_cmd_ready_o), msg_w'(1));

    // Asynchronous reset during the delay: write sticks, response is dropped.
    @(negedge clk_i);
    mem_cmd_i   = mk(e_cce_mem_wr, 40'h00_8000_0080, e_mem_size_64, 16'h0008, blk2);
    mem_cmd_v_i = 1'b1;
    @(posedge clk_i);
    #1 mem_cmd_v_i = 1'b0;
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    #2 reset_i = 1'b1;
    v_seen = 0;
    repeat (10) begin
      @(posedge clk_i);
      #1 if (mem_resp_v_o) v_seen++;
    end
    check("rst_delay_no_resp", msg_w'(v_seen), '0);
    txn("rst_delay_rd", mk(e_cce_mem_rd, 40'h00_8000_0080, e_mem_size_64, 16'h0009, '0), blk2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
